nucl_serializer: RTL and testbench
==================================

Name: nucl_serializer

Overview:
- Receiver-side counterpart of the packed nucleotide interface driven by the PE array.
- Accepts 32-bit words carrying 16 packed 2-bit nucleotides (the PE final_result format) and emits one ASCII nucleotide character per cycle over a valid/ready stream.
- Stops after a programmed sequence length, so partial final words are supported.
- Sits between the PE output and the host/UART/FIFO writeback path.

Parameters:
- WORD_W, 32, packed input word width; must be a multiple of 2.
- NUCL_PER_WORD, WORD_W/2 = 16, nucleotides per word (derived, not overridable).
- LEN_W, 16, width of the sequence-length count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a sequence; honoured only in IDLE.
- seq_len  in  LEN_W  nucleotide count; sampled on an accepted start.
- busy  out  1  high while not IDLE.
- in_valid  in  1  packed word valid.
- in_data  in  WORD_W  packed nucleotides; nucleotide 0 = [31:30], nucleotide 15 = [1:0].
- in_ready  out  1  block can accept in_data this cycle.
- out_valid  out  1  out_char valid.
- out_char  out  8  ASCII character.
- out_last  out  1  marks the final character of the sequence.
- out_ready  in  1  downstream accepts out_char.
- done  out  1  one-cycle pulse on sequence completion.

Behaviour:
- Reset is asynchronous, active-high. All outputs reset to 0, state resets to IDLE, counters and buffer clear. Reset mid-sequence discards the buffered word and remaining count, and emits no out_last or done.
- Encoding: 00→'A' (0x41), 01→'C' (0x43), 10→'G' (0x47), 11→'T' (0x54).
- States:
  - IDLE: in_ready=0, out_valid=0.
    - start with seq_len>0: latch chars_left=seq_len; go to FILL next cycle.
    - start with seq_len=0: done=1 next cycle; stay in IDLE.
  - FILL: buffer empty, in_ready=1, out_valid=0. On in_valid&in_ready, load the shift register and set idx=0; go to EMIT next cycle.
  - EMIT: out_valid=1. out_char = decode of buffer[WORD_W-1 -: 2].
    - out_last = (chars_left==1).
    - Each out_valid&out_ready handshake shifts the buffer left by 2, increments idx, and decrements chars_left.
- Word turnover in EMIT:
  - When a handshake consumes idx==15 and chars_left>1, in_ready is asserted combinationally in that same cycle (in_ready = out_ready & idx==15 & chars_left>1).
  - If in_valid is high in that cycle, the new word loads with zero bubble and the state stays EMIT.
  - Otherwise go to FILL.
- Completion: a handshake with out_last=1 ends the sequence.
  - Unconsumed nucleotides of the current word are dropped.
  - Next cycle: state=IDLE, done=1 for exactly one cycle, busy=0.
  - A start in that cycle is accepted.
- Outputs are stable while out_valid=1 and out_ready=0 (AXI-stream rule); out_char, out_last and buffer are held.
- No extra words are requested: total in_valid&in_ready handshakes per sequence = ceil(seq_len/16).
- start while busy is ignored, and seq_len is not re-sampled.
- Latency: word accepted at cycle t → first char valid at t+1. Sustained throughput is 1 char/cycle with continuous in_valid and out_ready.
- in_data is don't-care when in_valid=0.

Decomposition:
- Shared package nucl_pkg:
  - NUCL_W=2 and the WORD_W default.
  - Nucleotide code constants (NUCL_A=2'b00 … NUCL_T=2'b11) and the ASCII constants.
  - State encoding (IDLE/FILL/EMIT).
- The package is reused by the PE and by a future packer.
- One combinational sub-module, nucl_to_ascii (2-bit in, 8-bit out), shared with debug and monitor logic.

Test Plan:
- seq_len=16, in_data=0x51652D55, out_ready=1 → chars "CCACCGCCAGTCCCCC" on 16 consecutive cycles; out_last only on the 16th; done one cycle later; exactly 1 word accepted.
- seq_len=20, words 0xFFFFFFFF then 0x00000000 → 16×'T' then 4×'A', out_last on the 20th, 2 words accepted, in_ready=0 afterwards, no 3rd word taken.
- seq_len=16, in_data=0xE4E4E4E4, out_ready toggling 1,0,1,0 → "TGCA"×4 in order; out_char/out_last held during stalls; no loss or duplication.
- seq_len=48, in_valid held high with 3 words, out_ready=1 → 48 consecutive out_valid cycles with no bubble at the word boundaries.
- seq_len=0 with start → done high exactly one cycle later; out_valid and in_ready never assert.
- seq_len=32, reset asserted after 5 chars → all outputs 0 immediately (asynchronous); then start with seq_len=4 and in_data=0xAAAAAAAA → "GGGG", out_last on the 4th, done pulse.

Source files
------------

// File: rtl/nucl_pkg.sv
// Purpose: shared nucleotide encoding, ASCII codes and serializer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: NUCL_W and the default packed word width, 2-bit nucleotide codes,
// their ASCII characters, the serializer state enum and a character beat struct.
package nucl_pkg;

  localparam int NUCL_W     = 2;
  localparam int WORD_W_DEF = 32;

  // 2-bit nucleotide codes as produced by the PE array.
  localparam logic [NUCL_W-1:0] NUCL_A = 2'b00;
  localparam logic [NUCL_W-1:0] NUCL_C = 2'b01;
  localparam logic [NUCL_W-1:0] NUCL_G = 2'b10;
  localparam logic [NUCL_W-1:0] NUCL_T = 2'b11;

  // ASCII characters emitted for each code.
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_G = 8'h47;
  localparam logic [7:0] ASCII_T = 8'h54;

  // Serializer control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // One output character beat on the stream side.
  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } char_beat_t;

endpackage

// File: rtl/nucl_to_ascii.sv
// Purpose: decode one 2-bit nucleotide code into its ASCII character.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake involved.
//
// Ports:
//   nucl   in  2  nucleotide code (A=00, C=01, G=10, T=11)
//   ascii  out 8  ASCII character for the code
module nucl_to_ascii
  import nucl_pkg::*;
(
  input  logic [NUCL_W-1:0] nucl,
  output logic [7:0]        ascii
);

  always_comb begin
    ascii = ASCII_A;
    unique case (nucl)
      NUCL_A:  ascii = ASCII_A;
      NUCL_C:  ascii = ASCII_C;
      NUCL_G:  ascii = ASCII_G;
      NUCL_T:  ascii = ASCII_T;
      default: ascii = ASCII_A;
    endcase
  end

endmodule

// File: rtl/nucl_serializer.sv
// Purpose: unpack 32-bit words of 16 packed nucleotides into one ASCII char per cycle.
// Latency: word accepted at cycle t -> first char valid at t+1; 1 char/cycle sustained.
// Backpressure: out_ready low holds char/last/buffer; in_ready only when a word is needed.
//
// Ports:
//   clk, reset           clock (rising edge) and asynchronous active-high reset
//   start, seq_len       sequence start pulse (IDLE only) and nucleotide count
//   busy, done           not-IDLE flag and one-cycle completion pulse
//   in_valid/in_ready/in_data      packed word stream, nucleotide 0 in the MSBs
//   out_valid/out_ready/out_char/out_last   ASCII character stream
module nucl_serializer
  import nucl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int LEN_W  = 16
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  output logic              busy,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_char,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done
);

  localparam int NUCL_PER_WORD = WORD_W / NUCL_W;
  localparam int IDX_W = (NUCL_PER_WORD > 1) ? $clog2(NUCL_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUCL_PER_WORD - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic [WORD_W-1:0] shreg_q;   // current word, head nucleotide in the MSBs
  logic [IDX_W-1:0]  idx_q;     // position of the head nucleotide within the word
  logic [LEN_W-1:0]  left_q;    // characters still to emit, including the head
  logic              done_q;

  logic              start_go;
  logic              start_zero;
  logic              last_char;
  logic              word_end;
  logic              in_hs;
  logic              out_hs;
  logic [7:0]        head_char;
  char_beat_t        beat;

  nucl_to_ascii u_dec (
    .nucl  (shreg_q[WORD_W-1 -: NUCL_W]),
    .ascii (head_char)
  );

  // Shared decode of the control conditions.
  always_comb begin
    start_go   = (state_q == ST_IDLE) && start && (seq_len != '0);
    start_zero = (state_q == ST_IDLE) && start && (seq_len == '0);
    last_char  = (left_q == LEN_ONE);
    // Head is the final nucleotide of the word and more characters follow it,
    // so a fresh word is needed as soon as this one is consumed.
    word_end   = (idx_q == IDX_LAST) && (left_q > LEN_ONE);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (in_hs) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_hs) begin
          if (last_char) begin
            state_d = ST_IDLE;
          end else if (idx_q == IDX_LAST) begin
            // Zero-bubble turnover when the next word is already offered.
            state_d = in_hs ? ST_EMIT : ST_FILL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Character outputs are forced to zero outside EMIT so the
  // stream is quiet whenever nothing is valid.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_EMIT);
    beat.ch   = out_valid ? head_char : 8'h00;
    beat.last = out_valid && last_char;
    out_char  = beat.ch;
    out_last  = beat.last;
    // In EMIT the request for the next word rides on the same cycle as the
    // handshake that consumes the last nucleotide of the current word.
    in_ready  = (state_q == ST_FILL) ||
                ((state_q == ST_EMIT) && out_ready && word_end);
    done      = done_q;
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Datapath: shift buffer, nucleotide index, remaining count, done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= start_zero || (out_hs && last_char);

      if (start_go) begin
        left_q <= seq_len;
      end else if (out_hs) begin
        left_q <= left_q - 1'b1;
      end

      // A word load always wins over the shift: on turnover the shift would
      // only move out nucleotides of the word being replaced.
      if (in_hs) begin
        shreg_q <= in_data;
        idx_q   <= '0;
      end else if (out_hs) begin
        shreg_q <= {shreg_q[WORD_W-NUCL_W-1:0], {NUCL_W{1'b0}}};
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nucl_serializer.sv
module tb_nucl_serializer;

  typedef struct {
    byte ch;
    bit  last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] seq_len;
  logic        busy;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_last;
  logic        out_ready;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Model and stimulus state.
  exp_t        exp_q[$];
  logic [31:0] stage_q[$];
  logic [31:0] word_q[$];
  byte         got_q[$];
  string       nuc = "ACGT";
  bit          ready_toggle = 1'b0;
  bit          done_exp = 1'b0;
  bit          stalled_prev = 1'b0;
  logic [7:0]  prev_char = 8'h00;
  logic        prev_last = 1'b0;
  int          words_acc = 0;
  int          done_cnt = 0;
  int          run = 0;
  int          max_run = 0;
  int          act_seen = 0;

  nucl_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seq_len   (seq_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_last  (out_last),
    .out_ready (out_ready),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Word source and sink-ready driver: sample handshake away from the edge,
  // update inputs just after the rising edge.
  initial begin
    bit take;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (take && word_q.size() > 0) void'(word_q.pop_front());
      in_valid  = (word_q.size() > 0);
      in_data   = (word_q.size() > 0) ? word_q[0] : 32'hDEAD_BEEF;
      out_ready = ready_toggle ? ~out_ready : 1'b1;
    end
  end

  // Compare process: every cycle out of reset, checks the stream against the model.
  always @(negedge clk) begin
    bit nxt;
    if (reset) begin
      done_exp     = 1'b0;
      stalled_prev = 1'b0;
      run          = 0;
    end else begin
      nxt = 1'b0;
      chk("done", 32'(done), 32'(done_exp));
      if (done) done_cnt++;
      if (out_valid || in_ready) act_seen++;
      if (!busy) chk("idle_quiet", {30'd0, in_ready, out_valid}, 32'd0);
      if (start && !busy && seq_len == 16'd0) nxt = 1'b1;
      if (in_valid && in_ready) words_acc++;
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (stalled_prev) begin
          chk("stall_hold", {23'd0, out_char, out_last}, {23'd0, prev_char, prev_last});
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_char", 32'(out_char), 32'h0);
        end else begin
          chk("char", 32'(out_char), 32'(exp_q[0].ch));
          chk("last", 32'(out_last), 32'(exp_q[0].last));
          if (out_ready) begin
            got_q.push_back(byte'(out_char));
            if (exp_q[0].last) nxt = 1'b1;
            void'(exp_q.pop_front());
          end
        end
        stalled_prev = !out_ready;
        prev_char    = out_char;
        prev_last    = out_last;
      end else begin
        run          = 0;
        stalled_prev = 1'b0;
      end
      done_exp = nxt;
    end
  end

  // Build the expected character stream from stage_q and pulse start.
  task automatic launch(input int len, input bit toggle);
    logic [31:0] w;
    logic [1:0]  code;
    exp_t        e;
    @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
    words_acc = 0;
    max_run   = 0;
    done_cnt  = 0;
    act_seen  = 0;
    for (int i = 0; i < len; i++) begin
      w      = stage_q[i / 16];
      code   = w[31 - 2 * (i % 16) -: 2];
      e.ch   = nuc[code];
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
    word_q       = stage_q;
    ready_toggle = toggle;
    start        = 1'b1;
    seq_len      = 16'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_seq(input int exp_words, input int exp_left,
                            input string lit, input int exp_run);
    bit ok;
    for (int k = 0; k < 1000 && done_cnt == 0; k++) @(posedge clk);
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    ready_toggle = 1'b0;
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("words_taken", 32'(words_acc), 32'(exp_words));
    chk("words_left", 32'(word_q.size()), 32'(exp_left));
    chk("model_drained", 32'(exp_q.size()), 32'd0);
    if (lit.len() > 0) begin
      ok = (got_q.size() == lit.len());
      for (int i = 0; i < got_q.size() && ok; i++) if (got_q[i] != lit[i]) ok = 1'b0;
      chk({"literal_", lit}, 32'(ok), 32'd1);
    end
    if (exp_run > 0) chk("no_bubble_run", 32'(max_run), 32'(exp_run));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    seq_len = 16'd0;
    #3;
    chk("rst_outs", {26'd0, busy, in_ready, out_valid, out_last, done, 1'b0},  32'd0);
    chk("rst_char", 32'(out_char), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single full word.
    stage_q = {32'h51652D55};
    launch(16, 1'b0);
    finish_seq(1, 0, "CCACCGCCAGTCCCCC", 16);

    // Partial second word; the third offered word must stay unused.
    stage_q = {32'hFFFFFFFF, 32'h00000000, 32'h12345678};
    launch(20, 1'b0);
    finish_seq(2, 1, "TTTTTTTTTTTTTTTTAAAA", 20);
    word_q.delete();

    // Downstream stalls every other cycle.
    stage_q = {32'hE4E4E4E4};
    launch(16, 1'b1);
    finish_seq(1, 0, "TGCATGCATGCATGCA", 0);

    // Three back-to-back words, no bubble across word boundaries.
    stage_q = {32'h1B1B1B1B, 32'hE4E4E4E4, 32'h5A5A5A5A};
    launch(48, 1'b0);
    finish_seq(3, 0, "", 48);

    // Zero-length sequence.
    stage_q.delete();
    launch(0, 1'b0);
    finish_seq(0, 0, "", 0);
    chk("zero_len_quiet", 32'(act_seen), 32'd0);

    // Reset in the middle of a sequence.
    stage_q = {32'h0F0F0F0F, 32'hF0F0F0F0};
    launch(32, 1'b0);
    for (int k = 0; k < 200 && got_q.size() < 5; k++) @(posedge clk);
    chk("pre_reset_chars", 32'(got_q.size() >= 5), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_outs", {26'd0, busy, in_ready, out_valid, out_last, done, 1'b0}, 32'd0);
    chk("async_rst_char", 32'(out_char), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    word_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);

    stage_q = {32'hAAAAAAAA};
    launch(4, 1'b0);
    finish_seq(1, 0, "GGGG", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
